// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner: debounces presses and shifts hex digits into a 32-bit entry register.
// Optional auto-repeat of a held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_hex_entry #(
  parameter int SCAN_DIV       = 2048,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [32:1] data
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 2);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_hex_entry: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state;
  logic [3:0]    row_m, row_s;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic [1:0]    acc_cnt;   // keys seen this scan: 0, 1, or 2 meaning "two or more"
  logic [3:0]    acc_code;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep;
`endif

  logic [3:0] low;
  logic       col_one, sample, scan_end, scan_single, accept;
  logic [1:0] ridx;
  logic [1:0] nxt_cnt;
  logic [3:0] nxt_code, accept_code;

  assign col = ~(4'b0001 << col_idx);

  always_comb begin
    low      = ~row_s;
    col_one  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    ridx     = 2'd0;
    case (low)
      4'b0010: ridx = 2'd1;
      4'b0100: ridx = 2'd2;
      4'b1000: ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
    nxt_cnt  = acc_cnt;
    nxt_code = acc_code;
    if (low != 4'd0) begin
      if (col_one && acc_cnt == 2'd0) begin
        nxt_cnt  = 2'd1;
        nxt_code = {ridx, col_idx};
      end else begin
        nxt_cnt  = 2'd2;
      end
    end
    sample      = (div == DW'(SCAN_DIV - 1));
    scan_end    = sample && (col_idx == 2'd3);
    scan_single = (nxt_cnt == 2'd1);

    accept      = 1'b0;
    accept_code = (state == IDLE) ? nxt_code : cand;
    if (scan_end && scan_single) begin
      case (state)
        IDLE:     accept = (DEBOUNCE_SCANS == 1);
        DEBOUNCE: accept = (nxt_code == cand) && ((cnt + 1'b1) == CW'(DEBOUNCE_SCANS));
`ifdef KEYPAD_AUTOREPEAT_EN
        PRESSED:  accept = (nxt_code == cand) && ((rep + 1'b1) == RW'(REPEAT_SCANS));
`endif
        default:  accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      div       <= '0;
      col_idx   <= 2'd0;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'd0;
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
      data      <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep       <= '0;
`endif
    end else begin
      row_m <= row;
      row_s <= row_m;
      div   <= sample ? '0 : div + 1'b1;

      if (sample) begin
        col_idx  <= col_idx + 2'd1;
        acc_cnt  <= scan_end ? 2'd0 : nxt_cnt;
        acc_code <= scan_end ? 4'd0 : nxt_code;
      end

      if (scan_end) begin
        case (state)
          IDLE: if (scan_single) begin
            cand <= nxt_code;
            cnt  <= CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state    <= PRESSED;
              key_held <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep      <= '0;
`endif
            end else begin
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (scan_single && nxt_code == cand) begin
              cnt <= cnt + 1'b1;
              if ((cnt + 1'b1) == CW'(DEBOUNCE_SCANS)) begin
                state    <= PRESSED;
                key_held <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep      <= '0;
`endif
              end
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (!scan_single) begin
              state <= RELEASE;
              cnt   <= CW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
              rep   <= '0;
            end else if (nxt_code == cand) begin
              rep <= ((rep + 1'b1) == RW'(REPEAT_SCANS)) ? '0 : rep + 1'b1;
            end else begin
              rep <= '0;
`endif
            end
          end
          RELEASE: begin
            if (scan_single) begin
              state <= PRESSED;
              cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep   <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
              if ((cnt + 1'b1) >= CW'(DEBOUNCE_SCANS)) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      key_valid <= accept;
      if (accept) key_code <= accept_code;
      // clr takes priority over a same-cycle digit shift
      if (clr)         data <= '0;
      else if (accept) data <= {data[28:1], accept_code};
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: keypad matrix model, table of key presses, scoreboard of expected digits.
module tb_keypad_hex_entry;

  localparam int SCAN = 16;
  localparam int DEB  = 2;
  localparam int REP  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [32:1] data;
  logic [15:0] keys = 16'd0;

  int checks = 0, failures = 0, pulses = 0;
  logic [3:0]  exp_q[$];
  logic [32:1] exp_data = '0;

  always #5 clk = ~clk;

  keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clr(clr),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .data(data)
  );

  // key (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      logic [3:0] e;
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key_valid: got code %h expected no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", 64'(key_code), 64'(e));
      end
    end
  end

  function automatic logic [15:0] kb(input int r, input int c);
    logic [15:0] m;
    m = 16'd0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  // accepts expected from an aligned clean hold of n scans
  function automatic int n_acc(input int n);
    if (n < DEB) return 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    return 1 + (n - DEB) / REP;
`else
    return 1;
`endif
  endfunction

  task automatic expect_digits(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(code);
      exp_data = {exp_data[28:1], code};
    end
  endtask

  // returns #1 after the edge that starts a new scan (col back to column 0)
  task automatic align();
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = col;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (col == 4'b1110 && prev == 4'b0111) ok = 1'b1;
      prev = col;
    end
    check("align_timeout", 64'(ok), 64'd1);
  endtask

  task automatic press(input logic [15:0] m, input int scans, input logic exp_held);
    align();
    keys = m;
    repeat (SCAN * scans) @(posedge clk);
    #1;
    check("key_held_during", 64'(key_held), 64'(exp_held));
    keys = 16'd0;
    repeat (4 * SCAN) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] m;
    int          scans;
    logic [3:0]  code;
    logic        single;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n, p0;
    tbl[0]  = '{kb(1,2), 6, 4'h6, 1'b1};
    tbl[1]  = '{kb(0,1), 3, 4'h1, 1'b1};
    tbl[2]  = '{kb(0,2), 3, 4'h2, 1'b1};
    tbl[3]  = '{kb(0,3), 3, 4'h3, 1'b1};
    tbl[4]  = '{kb(1,0), 3, 4'h4, 1'b1};
    tbl[5]  = '{kb(1,1), 3, 4'h5, 1'b1};
    tbl[6]  = '{kb(1,2), 3, 4'h6, 1'b1};
    tbl[7]  = '{kb(1,3), 3, 4'h7, 1'b1};
    tbl[8]  = '{kb(2,0), 3, 4'h8, 1'b1};
    tbl[9]  = '{kb(2,1), 3, 4'h9, 1'b1};
    tbl[10] = '{kb(0,1), 1, 4'h1, 1'b1};
    tbl[11] = '{kb(0,1) | kb(2,3), 6, 4'h0, 1'b0};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 64'(col), 64'h E);
    check("rst_data", 64'(data), 64'd0);
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_key_held", 64'(key_held), 64'd0);
    rst_n = 1'b1;

    // reset in the middle of debounce discards the pending press
    p0 = pulses;
    align();
    keys = kb(0,0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    keys = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_col", 64'(col), 64'hE);
    check("midrst_key_held", 64'(key_held), 64'd0);
    repeat (4 * SCAN) @(posedge clk);
    #1;
    check("midrst_no_accept", 64'(pulses - p0), 64'd0);
    check("midrst_data", 64'(data), 64'd0);

    // table: clean presses, bounce, ghosting
    for (int i = 0; i < 12; i++) begin
      n = tbl[i].single ? n_acc(tbl[i].scans) : 0;
      p0 = pulses;
      expect_digits(tbl[i].code, n);
      press(tbl[i].m, tbl[i].scans, n > 0);
      check("pulse_count", 64'(pulses - p0), 64'(n));
      check("key_held_after", 64'(key_held), 64'd0);
      check("data", 64'(data), 64'(exp_data));
      if (i == 9) check("data_digits", 64'(data), 64'h2345_6789);
    end

    // clr on the accept cycle of key A
    expect_digits(4'hA, 1);
    exp_data = '0;
    align();
    keys = kb(2,2);
    repeat (31) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_key_valid", 64'(key_valid), 64'd1);
    check("clr_key_code", 64'(key_code), 64'hA);
    check("clr_data", 64'(data), 64'd0);
    repeat (SCAN - 1) @(posedge clk);
    #1;
    keys = 16'd0;
    repeat (4 * SCAN) @(posedge clk);
    #1;
    check("clr_data_after", 64'(data), 64'd0);

    // long hold of F: auto-repeat behaviour depends on the build
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_data = '0;
    n = n_acc(11);
    p0 = pulses;
    expect_digits(4'hF, n);
    press(kb(3,3), 11, 1'b1);
    check("hold_pulses", 64'(pulses - p0), 64'(n));
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_data", 64'(data), 64'h0000_FFFF);
`else
    check("hold_data", 64'(data), 64'h0000_000F);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
